// File: rtl/temporizador_pkg.sv
// Shared types and constants for the temporizador_param timer.
package temporizador_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } estado_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_LIMIT = 10;
    localparam int WRAP_CNT_W    = 8;
endpackage

// File: rtl/temporizador_contador_carga.sv
// Up-counter with synchronous clear, increment enable and terminal-count compare.
module contador_carga #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_lim,
    output logic [WIDTH-1:0] o_cont,
    output logic             o_tc
);
    logic [WIDTH-1:0] r_cont;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cont <= '0;
        end else if (i_inc) begin
            r_cont <= r_cont + WIDTH'(1);
        end
    end

    assign o_cont = r_cont;
    assign o_tc   = (r_cont == i_lim);
endmodule

// File: rtl/temporizador_param.sv
// Terminal-count timer with one-shot/auto-reload modes and start/stop control.
// Optional TEMPORIZADOR_WRAP_CNT_EN adds a saturating terminal-count counter output.
//
// state | meaning
// IDLE  | stopped, count cleared
// RUN   | counting enabled cycles toward r_lim
// DONE  | one-shot finished, count held at r_lim
module temporizador_param #(
    parameter int WIDTH         = temporizador_pkg::DEFAULT_WIDTH,
    parameter int DEFAULT_LIMIT = temporizador_pkg::DEFAULT_LIMIT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_cont,
    output logic             o_busy,
`ifdef TEMPORIZADOR_WRAP_CNT_EN
    output logic [7:0]       o_wrap_cnt,
`endif
    output logic             o_saida
);
    import temporizador_pkg::*;

    estado_t          r_state;
    logic [WIDTH-1:0] r_lim;
    logic             r_ar;
    logic             r_busy;
    logic             r_saida;

    logic             w_tc;
    logic             w_tc_run;
    logic             w_clr;
    logic             w_inc;

    // A terminal count only matters on an enabled RUN cycle.
    assign w_tc_run = (r_state == RUN) && i_en && w_tc;
    assign w_clr    = i_rst || i_stop || i_start || (w_tc_run && r_ar);
    assign w_inc    = (r_state == RUN) && i_en && !w_tc;

    contador_carga #(.WIDTH(WIDTH)) u_contador (
        .i_clk  (i_clk),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .i_lim  (r_lim),
        .o_cont (o_cont),
        .o_tc   (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_lim   <= WIDTH'(DEFAULT_LIMIT);
            r_ar    <= 1'b0;
            r_busy  <= 1'b0;
            r_saida <= 1'b0;
        end else begin
            r_saida <= 1'b0;
            if (i_stop) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else if (i_start) begin
                r_lim   <= i_limit;
                r_ar    <= i_auto_reload;
                r_state <= RUN;
                r_busy  <= 1'b1;
                // A restart landing on tc still reports the finished period.
                r_saida <= w_tc_run;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_tc_run) begin
                            r_saida <= 1'b1;
                            if (!r_ar) begin
                                r_state <= DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    DONE:    r_busy <= 1'b0;
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_saida = r_saida;

`ifdef TEMPORIZADOR_WRAP_CNT_EN
    logic [WRAP_CNT_W-1:0] r_wrap_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_stop || i_start) begin
            r_wrap_cnt <= '0;
        end else if (w_tc_run && (r_wrap_cnt != '1)) begin
            r_wrap_cnt <= r_wrap_cnt + WRAP_CNT_W'(1);
        end
    end

    assign o_wrap_cnt = r_wrap_cnt;
`endif
endmodule
